// File: rtl/fp_itof.sv
// Three-stage elastic int32/uint32 -> IEEE-754 single converter, round-to-nearest-even.
// Pipeline: sign/magnitude, normalize, then round and pack.
module fp_itof #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] int_in,
  input  logic                  is_unsigned,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] float_result,
  output logic                  inexact
);

  localparam int unsigned EXP_WIDTH  = 8;
  localparam int unsigned MANT_WIDTH = 23;
  localparam int unsigned BIAS       = 127;
  localparam int unsigned LZ_WIDTH   = 6;
  localparam int unsigned E_WIDTH    = 5;
  localparam int unsigned NORM_WIDTH = DATA_WIDTH - 1;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $fatal(1, "fp_itof: DATA_WIDTH must be 32");
  end

  // Stage registers
  logic                  v1_q, v2_q, v3_q;
  logic                  s1_sign_q, s1_zero_q;
  logic [DATA_WIDTH-1:0] s1_mag_q;
  logic                  s2_sign_q, s2_zero_q;
  logic [E_WIDTH-1:0]    s2_exp_q;
  logic [NORM_WIDTH-1:0] s2_norm_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  inx_q;

  // A stage may load when it is empty or its contents move on this cycle.
  logic en1_c, en2_c, en3_c;
  assign en3_c = !v3_q || out_ready;
  assign en2_c = !v2_q || en3_c;
  assign en1_c = !v1_q || en2_c;

  assign in_ready     = en1_c;
  assign out_valid    = v3_q;
  assign float_result = res_q;
  assign inexact      = inx_q;

  // S1: sign and magnitude
  logic                  sign_c;
  logic [DATA_WIDTH-1:0] mag_c;
  logic                  zero_c;
  always_comb begin
    sign_c = int_in[DATA_WIDTH-1] & ~is_unsigned;
    mag_c  = sign_c ? (~int_in + DATA_WIDTH'(1)) : int_in;
    zero_c = (mag_c == '0);
  end

  // S2: leading-zero count and normalization; highest set bit wins
  logic [LZ_WIDTH-1:0]   lz_c;
  logic [NORM_WIDTH-1:0] norm_c;
  logic [E_WIDTH-1:0]    e_c;
  always_comb begin
    lz_c = LZ_WIDTH'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (s1_mag_q[i]) lz_c = LZ_WIDTH'(DATA_WIDTH - 1 - i);
    end
    norm_c = NORM_WIDTH'(s1_mag_q << lz_c);
    e_c    = E_WIDTH'(LZ_WIDTH'(DATA_WIDTH - 1) - lz_c);
  end

  // S3: round to nearest even and pack
  logic [MANT_WIDTH-1:0] frac_c;
  logic                  guard_c, sticky_c, rup_c;
  logic [MANT_WIDTH:0]   frac_inc_c;
  logic [EXP_WIDTH-1:0]  bexp_c;
  logic [DATA_WIDTH-1:0] res_c;
  logic                  inx_c;
  always_comb begin
    frac_c     = s2_norm_q[NORM_WIDTH-1:NORM_WIDTH-MANT_WIDTH];
    guard_c    = s2_norm_q[7];
    sticky_c   = |s2_norm_q[6:0];
    rup_c      = guard_c & (sticky_c | s2_norm_q[8]);
    // Carry out of the fraction means the significand rolled over to 2.0.
    frac_inc_c = {1'b0, frac_c} + (MANT_WIDTH+1)'(rup_c);
    bexp_c     = EXP_WIDTH'(s2_exp_q) + EXP_WIDTH'(BIAS) + EXP_WIDTH'(frac_inc_c[MANT_WIDTH]);
    res_c      = {s2_sign_q, bexp_c, frac_inc_c[MANT_WIDTH-1:0]};
    inx_c      = guard_c | sticky_c;
    if (s2_zero_q) begin
      res_c = '0;
      inx_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_mag_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_norm_q <= '0;
      res_q     <= '0;
      inx_q     <= 1'b0;
    end else begin
      if (en1_c) v1_q <= in_valid;
      if (en2_c) v2_q <= v1_q;
      if (en3_c) v3_q <= v2_q;
      if (en1_c && in_valid) begin
        s1_sign_q <= sign_c;
        s1_zero_q <= zero_c;
        s1_mag_q  <= mag_c;
      end
      if (en2_c && v1_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s1_zero_q;
        s2_exp_q  <= e_c;
        s2_norm_q <= norm_c;
      end
      if (en3_c && v2_q) begin
        res_q <= res_c;
        inx_q <= inx_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_itof.sv
// Self-checking bench for fp_itof: directed table, backpressure, mid-flight reset
// and randomized traffic against an arithmetic reference model.
module tb_fp_itof;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_result;
  logic        inexact;

  fp_itof #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .int_in       (int_in),
    .is_unsigned  (is_unsigned),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .float_result (float_result),
    .inexact      (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    int          cyc;
    bit          lat;
    string       tag;
  } exp_t;

  typedef struct {
    string       name;
    logic        uns;
    logic [31:0] din;
    logic [31:0] res;
    logic        inx;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: round the exact magnitude to 24 significant bits by remainder comparison.
  function automatic logic [32:0] ref_cvt(input logic [31:0] x, input logic uns);
    longint unsigned m, q, r, half;
    int e, sh;
    bit neg, inx;
    neg = !uns && x[31];
    m = {32'd0, x};
    if (neg) m = 64'h1_0000_0000 - m;
    if (m == 0) return 33'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    inx = 1'b0;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && (q & 1) != 0)) q = q + 1;
      inx = (r != 0);
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {inx, neg, 8'(e + 127), 23'(q)};
  endfunction

  function automatic logic [31:0] gen_op();
    int unsigned sel, k;
    logic [31:0] b;
    sel = $urandom_range(0, 7);
    k   = $urandom_range(0, 31);
    b   = 32'd1 << k;
    case (sel)
      0: return 32'($urandom_range(0, 64));
      1: return b;
      2: return b - 32'd1;
      3: return b + 32'($urandom_range(0, 3));
      4: return ~32'($urandom_range(0, 64));
      5: return (($urandom() & 32'h00FF_FFFF) | 32'h0100_0001) << $urandom_range(0, 7);
      default: return $urandom();
    endcase
  endfunction

  // One clock: drive, sample handshakes before the edge, score, then advance.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic u, input logic ordy,
                       input logic [31:0] eres, input logic einx, input bit lat,
                       input string tag, output bit fired);
    exp_t e;
    in_valid    = iv;
    int_in      = d;
    is_unsigned = u;
    out_ready   = ordy;
    #1;
    fired = iv && in_ready;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h with nothing outstanding (cycle %0d)", float_result, cyc);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_result"}, float_result, e.res);
        chk({e.tag, "_inexact"}, 32'(inexact), 32'(e.inx));
        if (e.lat) chk({e.tag, "_latency"}, 32'(cyc - e.cyc), 32'd3);
      end
    end
    if (fired) sbq.push_back('{eres, einx, cyc, lat, tag});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name, input int budget);
    bit f;
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, "idle", f);
      n++;
    end
    chk(name, 32'(sbq.size()), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    bit          f;
    logic [32:0] m;
    logic [31:0] d, ops[5];
    logic        u, iv, ordy;
    int          idx, acc, n;

    tbl[0]  = '{"s_one",      1'b0, 32'd1,          32'h3F80_0000, 1'b0};
    tbl[1]  = '{"s_minus1",   1'b0, 32'hFFFF_FFFF,  32'hBF80_0000, 1'b0};
    tbl[2]  = '{"s_zero",     1'b0, 32'd0,          32'h0000_0000, 1'b0};
    tbl[3]  = '{"s_intmin",   1'b0, 32'h8000_0000,  32'hCF00_0000, 1'b0};
    tbl[4]  = '{"s_intmax",   1'b0, 32'h7FFF_FFFF,  32'h4F00_0000, 1'b1};
    tbl[5]  = '{"u_max",      1'b1, 32'hFFFF_FFFF,  32'h4F80_0000, 1'b1};
    tbl[6]  = '{"tie_down",   1'b0, 32'd16777217,   32'h4B80_0000, 1'b1};
    tbl[7]  = '{"tie_up",     1'b0, 32'd16777219,   32'h4B80_0002, 1'b1};
    tbl[8]  = '{"tie_even",   1'b0, 32'd16777221,   32'h4B80_0002, 1'b1};
    tbl[9]  = '{"u_msb",      1'b1, 32'h8000_0000,  32'h4F00_0000, 1'b0};
    tbl[10] = '{"exact24",    1'b0, 32'h00FF_FFFF,  32'h4B7F_FFFF, 1'b0};
    tbl[11] = '{"s_neg_tie",  1'b0, 32'hFEFF_FFFF,  32'hCB80_0000, 1'b1};

    rst = 1'b0; in_valid = 1'b0; int_in = '0; is_unsigned = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_float_result", float_result, 32'd0);
    chk("rst_inexact", 32'(inexact), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, back-to-back with the consumer always ready
    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].din, tbl[i].uns, 1'b1, tbl[i].res, tbl[i].inx, 1'b1, tbl[i].name, f);
      chk({tbl[i].name, "_accepted"}, 32'(f), 32'd1);
    end
    drain("table_drain", 10);

    // Backpressure: five operands offered while the consumer stalls
    ops[0] = 32'd100; ops[1] = 32'hFFFF_FFF9; ops[2] = 32'd3; ops[3] = 32'h1234_5678; ops[4] = 32'h0300_0005;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      m = ref_cvt(ops[idx], 1'b0);
      cycle(1'b1, ops[idx], 1'b0, 1'b0, m[31:0], m[32], 1'b0, "bp", f);
      if (f) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd3);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      m = ref_cvt(ops[idx], 1'b0);
      cycle(1'b1, ops[idx], 1'b0, 1'b0, m[31:0], m[32], 1'b0, "bp", f);
      if (f) idx++;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", float_result, sbq[0].res);
      chk("bp_hold_inexact", 32'(inexact), 32'(sbq[0].inx));
    end
    n = 0;
    while ((idx < 5 || sbq.size() != 0) && n < 30) begin
      d = (idx < 5) ? ops[idx] : 32'd0;
      m = ref_cvt(d, 1'b0);
      cycle(idx < 5, d, 1'b0, 1'b1, m[31:0], m[32], 1'b0, "bp", f);
      if (f) idx++;
      n++;
    end
    chk("bp_all_sent", 32'(idx), 32'd5);
    chk("bp_drained", 32'(sbq.size()), 32'd0);

    // Reset with three operands in flight
    for (int k = 0; k < 3; k++) begin
      d = 32'd1000 + 32'(k);
      m = ref_cvt(d, 1'b0);
      cycle(1'b1, d, 1'b0, 1'b1, m[31:0], m[32], 1'b0, "pre_rst", f);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_float_result", float_result, 32'd0);
    chk("async_rst_inexact", 32'(inexact), 32'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, "idle", f);
      chk("no_stale_output", 32'(out_valid), 32'd0);
    end
    cycle(1'b1, 32'hFFFF_FFF6, 1'b0, 1'b1, 32'hC120_0000, 1'b0, 1'b1, "post_rst", f);
    chk("post_rst_accepted", 32'(f), 32'd1);
    drain("post_rst_drain", 10);

    // Randomized traffic against the reference model
    acc = 0;
    n = 0;
    while (acc < 10000 && n < 60000) begin
      d    = gen_op();
      u    = 1'($urandom_range(0, 1));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      m    = ref_cvt(d, u);
      cycle(iv, d, u, ordy, m[31:0], m[32], 1'b0, "rnd", f);
      if (f) acc++;
      n++;
    end
    chk("rnd_operands_sent", 32'(acc), 32'd10000);
    drain("final_drain", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_itof.md
Name: fp_itof

Overview:
- Pipelined integer-to-float converter in the fp32_core cluster.
- Converts a 32-bit signed or unsigned integer to IEEE-754 single precision using round-to-nearest-even.
- Mirror stage of the float-to-int unit. Sits upstream of FP arithmetic and conversion stages, and feeds them from the integer register file.
- Elastic 3-stage pipeline with valid/ready handshaking on both sides.

Parameters:
- DATA_WIDTH, 32 (from gpu_parameters): operand/result width. Elaboration is fatal if it is not 32.
- EXP_WIDTH, 8 (localparam): exponent field width.
- MANT_WIDTH, 23 (localparam): fraction field width.
- BIAS, 127 (localparam): exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  converter can accept an operand this cycle.
- int_in  in  32  integer operand.
- is_unsigned  in  1  1 = treat int_in as unsigned, 0 = two's complement.
- out_valid  out  1  float_result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- float_result  out  32  IEEE-754 single result.
- inexact  out  1  result was rounded (value not exactly representable).

Behaviour:
- Reset (rst=0, asynchronous): all stage valids clear. out_valid=0, float_result=0, inexact=0. in_ready is high as soon as rst deasserts.
- Reset mid-operation discards all in-flight operands. No partial result is ever presented.
- Transfer rule: a transfer occurs on a rising edge when valid&&ready on the same side.
- Stage advance rule: stage k loads when stage k is empty or its contents advance this cycle. in_ready = !v1 || (stage1 advances). This path is combinational from out_ready through the stage valids; there are no skid buffers.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 per cycle.
- Ordering: results return in strict input order.
- Backpressure: with out_ready=0, float_result, inexact and out_valid hold stable. Up to 3 operands are held, then in_ready drops.
- S1, sign/magnitude:
  - sign = int_in[31] & !is_unsigned.
  - mag = sign ? (~int_in + 1) : int_in, as 32-bit unsigned. -2^31 gives mag 0x80000000.
  - zero flag = (mag==0).
- S2, normalize:
  - lz = leading-zero count of mag (0..31).
  - norm = mag << lz, so bit31 = 1 when nonzero.
  - e = 31 - lz.
- S3, round and pack:
  - fraction candidate = norm[30:8]. guard = norm[7]. sticky = |norm[6:0].
  - Round up when guard && (sticky || norm[8]).
  - Increment the 24-bit significand {1,norm[30:8]}. On carry-out, fraction = 0 and e = e+1.
  - Biased exponent = e + BIAS, range 127..159. Overflow and denormals are impossible.
  - Result = {sign, exp, frac}.
  - inexact = guard || sticky.
- Zero input gives +0.0 (0x00000000), inexact=0. Negative zero is never produced.
- Simultaneous input acceptance and output drain in the same cycle is legal and required for full throughput.
- in_valid may drop without a transfer. Operand fields are sampled only on a transfer.

Test Plan:
- Reset, then signed 1, -1, 0 back-to-back with out_ready=1 -> 0x3F800000, 0xBF800000, 0x00000000 on three consecutive cycles, starting 3 cycles after the first transfer; inexact=0.
- Signed 0x80000000 -> 0xCF000000, inexact=0. Signed 0x7FFFFFFF -> 0x4F000000, inexact=1. Unsigned 0xFFFFFFFF -> 0x4F800000, inexact=1.
- RNE ties: 16777217 -> 0x4B800000 (tie to even, down). 16777219 -> 0x4B800002 (tie to even, up). 16777221 -> 0x4B800002. All with inexact=1.
- Backpressure: stream 5 operands with out_ready=0 -> in_ready falls after 3 accepted, and the output holds the first result stable. Release out_ready -> all 5 results appear in order, none lost or duplicated.
- Assert rst low with 3 operands in flight -> out_valid=0 and float_result=0 immediately (asynchronous). After release, no stale results appear and the next operand completes with 3-cycle latency.
- Random 10k signed/unsigned operands with random in_valid/out_ready -> bit-exact match to a reference model of C casts (float)(int32_t) / (float)(uint32_t) under RNE, including the inexact flag.
